// File: rtl/cgra_array_4x4_if.sv
// rtl/cgra_array_4x4_if.sv - config-load and data-memory handshake bundle for cgra_array_4x4
// Per-tile config ports are indexed [0:15], per-bank memory ports [0:3].
interface cgra_array_4x4_if;
  logic        recv_waddr__en  [0:15];
  logic [1:0]  recv_waddr__msg [0:15];
  logic        recv_waddr__rdy [0:15];
  logic        recv_wopt__en   [0:15];
  logic [48:0] recv_wopt__msg  [0:15];
  logic        recv_wopt__rdy  [0:15];

  logic        data_mem__recv_waddr__en1  [0:3];
  logic [6:0]  data_mem__recv_waddr__msg1 [0:3];
  logic        data_mem__recv_waddr__rdy1 [0:3];
  logic        data_mem__recv_wdata__en1  [0:3];
  logic [17:0] data_mem__recv_wdata__msg1 [0:3];
  logic        data_mem__recv_wdata__rdy1 [0:3];
  logic        data_mem__recv_raddr__en1  [0:3];
  logic [6:0]  data_mem__recv_raddr__msg1 [0:3];
  logic        data_mem__recv_raddr__rdy1 [0:3];
  logic        data_mem__send_rdata__en1  [0:3];
  logic [17:0] data_mem__send_rdata__msg1 [0:3];
  logic        data_mem__send_rdata__rdy1 [0:3];

  modport slave (
    input  recv_waddr__en, recv_waddr__msg, recv_wopt__en, recv_wopt__msg,
    output recv_waddr__rdy, recv_wopt__rdy,
    output data_mem__recv_waddr__en1, data_mem__recv_waddr__msg1,
    input  data_mem__recv_waddr__rdy1,
    output data_mem__recv_wdata__en1, data_mem__recv_wdata__msg1,
    input  data_mem__recv_wdata__rdy1,
    output data_mem__recv_raddr__en1, data_mem__recv_raddr__msg1,
    input  data_mem__recv_raddr__rdy1,
    input  data_mem__send_rdata__en1, data_mem__send_rdata__msg1,
    output data_mem__send_rdata__rdy1
  );

  modport master (
    output recv_waddr__en, recv_waddr__msg, recv_wopt__en, recv_wopt__msg,
    input  recv_waddr__rdy, recv_wopt__rdy,
    input  data_mem__recv_waddr__en1, data_mem__recv_waddr__msg1,
    output data_mem__recv_waddr__rdy1,
    input  data_mem__recv_wdata__en1, data_mem__recv_wdata__msg1,
    output data_mem__recv_wdata__rdy1,
    input  data_mem__recv_raddr__en1, data_mem__recv_raddr__msg1,
    output data_mem__recv_raddr__rdy1,
    output data_mem__send_rdata__en1, data_mem__send_rdata__msg1,
    input  data_mem__send_rdata__rdy1
  );
endinterface

// File: rtl/cgra_array_4x4.sv
// rtl/cgra_array_4x4.sv - 4x4 CGRA: per-tile 4-entry config memory, 16-bit FU, registered mesh
// Left-column tiles own one data-memory bank each; the whole array stalls on any pending memory op.
module cgra_array_4x4 #(
  parameter int NUM_TILES   = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int MEM_AW      = 7
) (
  input  logic             clk,
  input  logic             reset,
  cgra_array_4x4_if.slave  bus
);
  localparam int PCW = $clog2(KERNEL_SIZE);
  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_W = 2;
  localparam int DIR_E = 3;

  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_MUL = 6'd3, OP_AND = 6'd4,
                         OP_OR  = 6'd5, OP_XOR = 6'd6, OP_PASS = 6'd7, OP_LD = 6'd8,
                         OP_ST  = 6'd9;

  // Internal words are {payload16, pred}; bypass exists only on the memory ports.
  typedef logic [16:0] word_t;

  logic [48:0]          cfg_q  [NUM_TILES][KERNEL_SIZE];
  logic [48:0]          cfg_d  [NUM_TILES][KERNEL_SIZE];
  logic [NUM_TILES-1:0] loaded_q, loaded_d;
  logic [PCW-1:0]       pc_q, pc_d;
  word_t                out_q  [NUM_TILES][4];
  word_t                out_d  [NUM_TILES][4];
  word_t                out_nx [NUM_TILES][4];
  word_t                res_q  [NUM_TILES];
  word_t                res_d  [NUM_TILES];
  word_t                fu_res [NUM_TILES];
  logic                 run, stall, advance;
  logic                 unused_bits;

  function automatic word_t pick(input logic [2:0] s, input word_t n, input word_t so,
                                 input word_t w, input word_t e, input word_t r);
    case (s)
      3'd1:    pick = n;
      3'd2:    pick = so;
      3'd3:    pick = w;
      3'd4:    pick = e;
      3'd5:    pick = r;
      default: pick = '0;
    endcase
  endfunction

  always_comb begin : comb_blk
    logic [48:0] cur;
    logic [2:0]  osel;
    word_t       in_n, in_s, in_w, in_e, a, b;
    logic [15:0] prod;
    logic        pp;
    cur = '0; osel = '0; in_n = '0; in_s = '0; in_w = '0; in_e = '0;
    a = '0; b = '0; prod = '0; pp = 1'b0;
    cfg_d       = cfg_q;
    loaded_d    = loaded_q;
    pc_d        = pc_q;
    out_d       = out_q;
    res_d       = res_q;
    out_nx      = out_q;
    fu_res      = res_q;
    stall       = 1'b0;
    unused_bits = 1'b0;
    run         = &loaded_q;

    for (int k = 0; k < 4; k++) begin
      bus.data_mem__recv_waddr__en1[k]  = 1'b0;
      bus.data_mem__recv_waddr__msg1[k] = '0;
      bus.data_mem__recv_wdata__en1[k]  = 1'b0;
      bus.data_mem__recv_wdata__msg1[k] = '0;
      bus.data_mem__recv_raddr__en1[k]  = 1'b0;
      bus.data_mem__recv_raddr__msg1[k] = '0;
      bus.data_mem__send_rdata__rdy1[k] = ~reset;
      unused_bits = unused_bits ^ bus.data_mem__send_rdata__msg1[k][0];
    end

    for (int t = 0; t < NUM_TILES; t++) begin
      bus.recv_waddr__rdy[t] = ~reset;
      bus.recv_wopt__rdy[t]  = ~reset;
      if (bus.recv_waddr__en[t] && bus.recv_wopt__en[t]) begin
        cfg_d[t][bus.recv_waddr__msg[t]] = bus.recv_wopt__msg[t];
        if (bus.recv_waddr__msg[t] == 2'd3) loaded_d[t] = 1'b1;
      end

      cur  = cfg_q[t][pc_q];
      unused_bits = unused_bits ^ (^{cur[41:36], cur[29:18], cur[5:0]});
      // Neighbour indices wrap with modulo so every select stays in range; edges are masked to zero.
      in_n = (t >= 4)            ? out_q[(t + NUM_TILES - 4) % NUM_TILES][DIR_S] : '0;
      in_s = (t < NUM_TILES - 4) ? out_q[(t + 4) % NUM_TILES][DIR_N]             : '0;
      in_w = (t % 4 != 0)        ? out_q[(t + NUM_TILES - 1) % NUM_TILES][DIR_E] : '0;
      in_e = (t % 4 != 3)        ? out_q[(t + 1) % NUM_TILES][DIR_W]             : '0;
      a    = pick(cur[32:30], in_n, in_s, in_w, in_e, res_q[t]);
      b    = pick(cur[35:33], in_n, in_s, in_w, in_e, res_q[t]);
      pp   = cur[42] ? (a[0] & b[0]) : 1'b1;
      prod = a[16:1] * b[16:1];

      case (cur[48:43])
        OP_ADD:  fu_res[t] = {a[16:1] + b[16:1], pp};
        OP_SUB:  fu_res[t] = {a[16:1] - b[16:1], pp};
        OP_MUL:  fu_res[t] = {prod, pp};
        OP_AND:  fu_res[t] = {a[16:1] & b[16:1], pp};
        OP_OR:   fu_res[t] = {a[16:1] | b[16:1], pp};
        OP_XOR:  fu_res[t] = {a[16:1] ^ b[16:1], pp};
        OP_PASS: fu_res[t] = {a[16:1], pp};
        OP_LD: begin
          if (t % 4 == 0) begin
            bus.data_mem__recv_raddr__en1[t/4]  = run;
            bus.data_mem__recv_raddr__msg1[t/4] = run ? a[MEM_AW:1] : '0;
            fu_res[t] = bus.data_mem__send_rdata__msg1[t/4][17:1];
            stall = stall | (run & ~(bus.data_mem__recv_raddr__rdy1[t/4] &
                                     bus.data_mem__send_rdata__en1[t/4]));
          end
        end
        OP_ST: begin
          if (t % 4 == 0) begin
            bus.data_mem__recv_waddr__en1[t/4]  = run;
            bus.data_mem__recv_waddr__msg1[t/4] = run ? a[MEM_AW:1] : '0;
            bus.data_mem__recv_wdata__en1[t/4]  = run;
            bus.data_mem__recv_wdata__msg1[t/4] = run ? {b, 1'b0} : '0;
            stall = stall | (run & ~(bus.data_mem__recv_waddr__rdy1[t/4] &
                                     bus.data_mem__recv_wdata__rdy1[t/4]));
          end
        end
        default: fu_res[t] = res_q[t];
      endcase

      for (int k = 0; k < 4; k++) begin
        osel = cur[6 + 3*k +: 3];
        out_nx[t][k] = (osel == 3'd0) ? out_q[t][k] : pick(osel, in_n, in_s, in_w, in_e, res_q[t]);
      end
    end

    advance = run & ~stall;
    if (advance) begin
      pc_d  = pc_q + 1'b1;
      res_d = fu_res;
      out_d = out_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q    <= '{default: '0};
      loaded_q <= '0;
      pc_q     <= '0;
      out_q    <= '{default: '0};
      res_q    <= '{default: '0};
    end else begin
      cfg_q    <= cfg_d;
      loaded_q <= loaded_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      res_q    <= res_d;
    end
  end
endmodule

// File: tb/tb_cgra_array_4x4.sv
// tb/tb_cgra_array_4x4.sv - directed self-checking bench for cgra_array_4x4
// Kernel: tile4 feeds addresses 5/6 north to tile0; tile0 loads 7, tile1 doubles it, tile0 stores 14.
module tb_cgra_array_4x4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cgra_array_4x4_if ifc();
  cgra_array_4x4 dut (.clk(clk), .reset(reset), .bus(ifc));

  int checks = 0;
  int fails  = 0;
  logic [17:0] mem  [4][128];
  logic [48:0] prog [16][4];

  always_comb
    for (int b = 0; b < 4; b++)
      ifc.data_mem__send_rdata__msg1[b] = mem[b][ifc.data_mem__recv_raddr__msg1[b]];

  function automatic logic [48:0] mk(input logic [5:0] op, input logic p, input logic [2:0] fa,
                                     input logic [2:0] fb, input logic [2:0] on, input logic [2:0] os,
                                     input logic [2:0] ow, input logic [2:0] oe);
    mk = {op, p, 3'd0, 3'd0, fb, fa, 12'd0, oe, ow, os, on, 6'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bank_chk(input string tag, input int b, input logic ren, input logic [6:0] ra,
                          input logic wen, input logic [6:0] wa, input logic [17:0] wd);
    string s;
    s = $sformatf("%s_b%0d", tag, b);
    chk({s, "_ren"}, ifc.data_mem__recv_raddr__en1[b], ren);
    if (ren) chk({s, "_raddr"}, ifc.data_mem__recv_raddr__msg1[b], ra);
    chk({s, "_wen"}, ifc.data_mem__recv_waddr__en1[b], wen);
    chk({s, "_wden"}, ifc.data_mem__recv_wdata__en1[b], wen);
    if (wen) begin
      chk({s, "_waddr"}, ifc.data_mem__recv_waddr__msg1[b], wa);
      chk({s, "_wdata"}, ifc.data_mem__recv_wdata__msg1[b], wd);
    end
  endtask

  task automatic idle_chk(input string tag);
    for (int b = 0; b < 4; b++) bank_chk(tag, b, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
  endtask

  task automatic rdy_chk(input string tag, input logic v);
    for (int t = 0; t < 16; t++) begin
      chk($sformatf("%s_waddr_rdy%0d", tag, t), ifc.recv_waddr__rdy[t], v);
      chk($sformatf("%s_wopt_rdy%0d", tag, t), ifc.recv_wopt__rdy[t], v);
    end
    for (int b = 0; b < 4; b++) chk($sformatf("%s_rdata_rdy%0d", tag, b), ifc.data_mem__send_rdata__rdy1[b], v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int e, input int last_tile);
    for (int t = 0; t < 16; t++) begin
      ifc.recv_waddr__en[t]  = (t <= last_tile);
      ifc.recv_waddr__msg[t] = 2'(e);
      ifc.recv_wopt__en[t]   = (t <= last_tile);
      ifc.recv_wopt__msg[t]  = prog[t][e];
    end
    tick();
    for (int t = 0; t < 16; t++) begin
      ifc.recv_waddr__en[t] = 1'b0;
      ifc.recv_wopt__en[t]  = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int t = 0; t < 16; t++) begin
      ifc.recv_waddr__en[t] = 1'b0; ifc.recv_waddr__msg[t] = '0;
      ifc.recv_wopt__en[t]  = 1'b0; ifc.recv_wopt__msg[t]  = '0;
      for (int e = 0; e < 4; e++) prog[t][e] = '0;
    end
    for (int b = 0; b < 4; b++) begin
      ifc.data_mem__recv_waddr__rdy1[b] = 1'b1;
      ifc.data_mem__recv_wdata__rdy1[b] = 1'b1;
      ifc.data_mem__recv_raddr__rdy1[b] = 1'b1;
      ifc.data_mem__send_rdata__en1[b]  = 1'b1;
      for (int a = 0; a < 128; a++) mem[b][a] = '0;
    end
    mem[0][5] = {16'd7, 1'b1, 1'b0};
    mem[1][0] = {16'd5, 1'b1, 1'b0};
    mem[1][5] = {16'd6, 1'b1, 1'b0};
    mem[2][0] = {16'h0100, 1'b1, 1'b0};
    mem[3][0] = {16'd1, 1'b1, 1'b0};

    prog[0][0]  = mk(6'd8, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[0][1]  = mk(6'd9, 1'b0, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd5);
    prog[1][2]  = mk(6'd1, 1'b0, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[1][3]  = mk(6'd0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0);
    prog[4][0]  = mk(6'd0, 1'b0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0);
    prog[4][1]  = mk(6'd8, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[4][3]  = mk(6'd8, 1'b0, 3'd5, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0);
    prog[5][0]  = mk(6'd8, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[8][0]  = mk(6'd8, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[8][1]  = mk(6'd3, 1'b0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[8][2]  = mk(6'd9, 1'b0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[12][0] = mk(6'd8, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[12][1] = mk(6'd2, 1'b1, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    prog[12][2] = mk(6'd9, 1'b0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);

    #1;
    idle_chk("reset");
    rdy_chk("reset", 1'b0);
    tick();
    reset = 1'b0;
    #1;
    rdy_chk("post_reset", 1'b1);
    tick();
    idle_chk("post_reset_idle");

    for (int e = 0; e < 4; e++) load_entry(e, (e < 3) ? 15 : 14);
    idle_chk("partial_load");
    tick();
    idle_chk("partial_load2");

    ifc.recv_waddr__en[15] = 1'b1; ifc.recv_waddr__msg[15] = 2'd3;
    tick();
    ifc.recv_waddr__en[15] = 1'b0;
    idle_chk("waddr_only");

    ifc.recv_waddr__en[15] = 1'b1; ifc.recv_waddr__msg[15] = 2'd3;
    ifc.recv_wopt__en[15]  = 1'b1; ifc.recv_wopt__msg[15]  = prog[15][3];
    tick();
    ifc.recv_waddr__en[15] = 1'b0; ifc.recv_wopt__en[15] = 1'b0;

    bank_chk("i1p0", 0, 1'b1, 7'd0, 1'b0, 7'd0, 18'd0);
    bank_chk("i1p0", 1, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
    bank_chk("i1p0", 2, 1'b1, 7'd0, 1'b0, 7'd0, 18'd0);
    tick();
    bank_chk("i1p1", 0, 1'b0, 7'd0, 1'b1, 7'd0, 18'h00000);
    bank_chk("i1p1", 1, 1'b1, 7'd0, 1'b0, 7'd0, 18'd0);
    tick();
    bank_chk("i1p2_mul", 2, 1'b0, 7'd0, 1'b1, 7'd0, 18'h00002);
    bank_chk("i1p2_sub", 3, 1'b0, 7'd0, 1'b1, 7'd0, 18'h3FFFC);
    tick();
    bank_chk("i1p3", 1, 1'b1, 7'd5, 1'b0, 7'd0, 18'd0);
    bank_chk("i1p3", 0, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
    tick();
    bank_chk("i2p0_wrap", 0, 1'b1, 7'd5, 1'b0, 7'd0, 18'd0);
    bank_chk("i2p0_nonleft_ld", 1, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
    tick();
    bank_chk("i2p1", 0, 1'b0, 7'd0, 1'b1, 7'd6, 18'h00002);
    tick();
    tick();
    tick();

    ifc.data_mem__send_rdata__en1[0] = 1'b0;
    bank_chk("i3p0", 0, 1'b1, 7'd5, 1'b0, 7'd0, 18'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bank_chk($sformatf("ld_stall%0d", i), 0, 1'b1, 7'd5, 1'b0, 7'd0, 18'd0);
      bank_chk($sformatf("ld_stall%0d", i), 1, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
      bank_chk($sformatf("ld_stall%0d", i), 2, 1'b1, 7'd0, 1'b0, 7'd0, 18'd0);
    end
    ifc.data_mem__send_rdata__en1[0] = 1'b1;
    tick();
    bank_chk("i3p1_add_chain", 0, 1'b0, 7'd0, 1'b1, 7'd6, {16'd14, 1'b1, 1'b0});

    ifc.data_mem__recv_waddr__rdy1[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      bank_chk($sformatf("st_stall%0d", i), 0, 1'b0, 7'd0, 1'b1, 7'd6, 18'h0003A);
      bank_chk($sformatf("st_stall%0d", i), 1, 1'b1, 7'd0, 1'b0, 7'd0, 18'd0);
      bank_chk($sformatf("st_stall%0d", i), 2, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);
    end
    ifc.data_mem__recv_waddr__rdy1[0] = 1'b1;
    tick();
    bank_chk("i3p2", 2, 1'b0, 7'd0, 1'b1, 7'd0, 18'h00002);
    bank_chk("i3p2", 0, 1'b0, 7'd0, 1'b0, 7'd0, 18'd0);

    reset = 1'b1;
    #1;
    idle_chk("mid_reset");
    rdy_chk("mid_reset", 1'b0);
    tick();
    reset = 1'b0;
    #1;
    rdy_chk("after_mid_reset", 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk($sformatf("unloaded%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
